ps2_kbd_rx: RTL



---
 rtl/ps2_kbd_rx.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver and scan-code set 2 decoder.
//
// Conditions the asynchronous open-collector PS/2 clock/data pair (2-FF
// synchronizer plus glitch filter), deframes 11-bit device-to-host frames
// (start, 8 data LSB first, odd parity, stop) and folds E0/F0 prefixes into
// an 11-bit key word.
//
// Parameters:
//   FILTER_LEN  - consecutive identical samples before a filtered line changes
//   TIMEOUT_CYC - clk_sys cycles without a clock fall before a frame aborts
//
// Ports:
//   clk_sys    in   system clock
//   reset      in   asynchronous active-high reset
//   ps2_clk    in   PS/2 clock line (async, idle high)
//   ps2_data   in   PS/2 data line (async, idle high)
//   byte_data  out  [7:0] last correctly received raw byte
//   byte_valid out  one-cycle pulse when byte_data updates
//   frame_err  out  one-cycle pulse on parity, stop-bit or timeout error
//   busy       out  high while a frame is in progress
//   ps2_key    out  [10] toggle per event, [9] pressed, [8] extended, [7:0] code
//   err_count  out  [7:0] saturating frame error count
//                   (only when PS2_KBD_RX_ERRCNT_EN is defined)
module ps2_kbd_rx #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 32000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        frame_err,
    output logic        busy,
    output logic [10:0] ps2_key
`ifdef PS2_KBD_RX_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_clk_filt;
    logic          r_data_filt;
    logic [FW-1:0] r_clk_cnt;
    logic [FW-1:0] r_data_cnt;
    logic          r_clk_prev;
    logic          w_fall;

    // NOTE: synchronizers and filters reset to 1 (the idle line level) so
    // leaving reset never looks like a clock falling edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_filt  <= 1'b1;
            r_data_filt <= 1'b1;
            r_clk_cnt   <= '0;
            r_data_cnt  <= '0;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_clk_prev  <= r_clk_filt;

            // Filter: count consecutive samples that disagree with the
            // filtered value; any agreeing sample restarts the count.
            if (r_clk_sync[1] == r_clk_filt) begin
                r_clk_cnt <= '0;
            end else if (r_clk_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_sync[1];
                r_clk_cnt  <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end

            if (r_data_sync[1] == r_data_filt) begin
                r_data_cnt <= '0;
            end else if (r_data_cnt == FW'(FILTER_LEN - 1)) begin
                r_data_filt <= r_data_sync[1];
                r_data_cnt  <= '0;
            end else begin
                r_data_cnt <= r_data_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_filt;

    // ------------------------------------------------------------------
    // Frame FSM, timeout and decoder
    // ------------------------------------------------------------------
    state_t        r_state;
    logic          r_busy;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          r_par_ok;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_err;
    logic          r_ext;
    logic          r_rel;
    logic [10:0]   r_key;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_par_ok  <= 1'b0;
            r_to_cnt  <= '0;
            r_byte    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
            r_key     <= '0;
        end else begin
            // NOTE: pulses default low here and are raised below; with
            // non-blocking assignments the later assignment wins.
            r_valid <= 1'b0;
            r_err   <= 1'b0;

            if (w_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (!r_data_filt) begin
                            r_state   <= S_DATA;
                            r_busy    <= 1'b1;
                            r_bit_cnt <= '0;
                            r_par     <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        r_shift <= {r_data_filt, r_shift[7:1]};
                        r_par   <= r_par ^ r_data_filt;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        // Odd parity: data bits plus parity bit hold an odd count of ones.
                        r_par_ok <= r_par ^ r_data_filt;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (r_data_filt && r_par_ok) begin
                            r_byte  <= r_shift;
                            r_valid <= 1'b1;
                            case (r_shift)
                                8'hE0: r_ext <= 1'b1;
                                8'hF0: r_rel <= 1'b1;
                                8'hE1: ;  // pause prefix: leave flags and key alone
                                8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                                    r_ext <= 1'b0;
                                    r_rel <= 1'b0;
                                end
                                default: begin
                                    r_key <= {~r_key[10], ~r_rel, r_ext, r_shift};
                                    r_ext <= 1'b0;
                                    r_rel <= 1'b0;
                                end
                            endcase
                        end else begin
                            r_err <= 1'b1;
                            r_ext <= 1'b0;
                            r_rel <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_to_cnt <= '0;
                    r_err    <= 1'b1;
                    r_ext    <= 1'b0;
                    r_rel    <= 1'b0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    assign byte_data  = r_byte;
    assign byte_valid = r_valid;
    assign frame_err  = r_err;
    assign busy       = r_busy;
    assign ps2_key    = r_key;

`ifdef PS2_KBD_RX_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (r_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
